// File: rtl/adder_pipelined.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES ripple chunks with valid/ready flow.
// Define ADDER_PIPELINED_SUB_EN to add the in_sub port (a - b via inverted b and carry-in).
module adder_pipelined #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_PIPELINED_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned C = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : gen_bad_params
        $error("adder_pipelined: WIDTH must be >= 1 and a multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] load;

`ifdef ADDER_PIPELINED_SUB_EN
    assign b_eff   = in_b ^ {WIDTH{in_sub}};
    assign cin_eff = in_cin ^ in_sub;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        logic down_ready;
        down_ready = out_ready;
        load       = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            down_ready = !valid[k] || down_ready;
            load[k]    = down_ready;
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        localparam int unsigned InW  = WIDTH - k * C;
        localparam int unsigned Done = (k + 1) * C;
        localparam int unsigned Rem  = WIDTH - Done;

        logic [InW-1:0]  src_a;
        logic [InW-1:0]  src_b;
        logic            src_c;
        logic            src_valid;
        logic [C-1:0]    chunk_sum;
        logic            chunk_cout;
        logic [Done-1:0] sum_d;
        logic [Done-1:0] sum_q;
        logic            carry_q;
        logic            valid_q;

        if (k == 0) begin : gen_src
            assign src_a     = in_a;
            assign src_b     = b_eff;
            assign src_c     = cin_eff;
            assign src_valid = in_valid;
            assign sum_d     = chunk_sum;
        end else begin : gen_src
            assign src_a     = gen_stage[k-1].gen_rem.a_q;
            assign src_b     = gen_stage[k-1].gen_rem.b_q;
            assign src_c     = gen_stage[k-1].carry_q;
            assign src_valid = gen_stage[k-1].valid_q;
            assign sum_d     = {chunk_sum, gen_stage[k-1].sum_q};
        end

        // Gate-level ripple over the low C bits of the pending operands.
        always_comb begin
            logic c;
            c         = src_c;
            chunk_sum = '0;
            for (int unsigned i = 0; i < C; i++) begin
                chunk_sum[i] = src_a[i] ^ src_b[i] ^ c;
                c = (src_a[i] & src_b[i]) | (src_a[i] & c) | (src_b[i] & c);
            end
            chunk_cout = c;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (load[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    carry_q <= chunk_cout;
                    sum_q   <= sum_d;
                end
            end
        end

        assign valid[k] = valid_q;

        // Operand bits not yet consumed travel with the partial sum.
        if (Rem > 0) begin : gen_rem
            logic [Rem-1:0] a_q;
            logic [Rem-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load[k] && src_valid) begin
                    a_q <= src_a[C +: Rem];
                    b_q <= src_b[C +: Rem];
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].valid_q;
    assign out_sum   = gen_stage[STAGES-1].sum_q;
    assign out_cout  = gen_stage[STAGES-1].carry_q;

endmodule
